// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arb_mux block family.
// Arbitration mode encodings and an elaboration-time log2.
package arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Pointer-based priority picker for round-robin arbitration.
// Grants the first requester at or above ptr, wrapping modulo N.
module arb_mux_rr_pick
    import arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt,
    output logic            gnt_v
);

    int   idx;
    logic found;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt   = SELW'(idx);
                found = 1'b1;
            end
        end
        gnt_v = |req;
    end

endmodule

// File: rtl/arb_mux.sv
// Registered N-way mux with valid/ready inputs and one output slot.
// Grant is steered by sel or chosen round-robin, set by MODE.
module arb_mux
    import arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_FIXED,
    localparam int SELW  = clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    logic            load;
    logic [SELW-1:0] gnt;
    logic            gnt_v;

    assign load = !out_valid || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] ptr;
            logic            unused_sel;

            assign unused_sel = ^sel;

            arb_mux_rr_pick #(
                .N    (N),
                .SELW (SELW)
            ) u_pick (
                .req   (in_valid),
                .ptr   (ptr),
                .gnt   (gnt),
                .gnt_v (gnt_v)
            );

            // Advance past the winner so it drops to lowest priority.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ptr <= '0;
                end else if (load && gnt_v) begin
                    ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
                end
            end
        end else begin : g_fixed
            logic [(1 << SELW)-1:0] vpad;

            // Zero-pad so an out-of-range sel reads as not valid.
            always_comb begin
                vpad        = '0;
                vpad[N-1:0] = in_valid;
            end

            assign gnt   = sel;
            assign gnt_v = vpad[sel];
        end
    endgenerate

    // One-hot ready for the granted input; silent while in reset.
    always_comb begin
        in_ready = '0;
        if (!reset && load && gnt_v) begin
            in_ready[gnt] = 1'b1;
        end
    end

    // Output slot: refill on load, empty when nothing is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            if (gnt_v) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gnt)*WIDTH +: WIDTH];
                out_src   <= gnt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
